// File: rtl/frame_buffer_pingpong.sv
// Two-bank ping-pong frame buffer: a writer fills one bank while a reader streams
// the last completed frame out of the other bank with a valid/ready handshake.
module frame_buffer_pingpong #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 76800
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_sof_i,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_frame_done_o,
    input  logic             rd_start_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_last_o,
    output logic             rd_busy_o,
    output logic             frame_avail_o,
    output logic [15:0]      drop_count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = $clog2(DEPTH + 1);

    typedef enum logic {WAIT_SOF, WRITE} wr_state_t;
    typedef enum logic {IDLE, STREAM} rd_state_t;

    logic [WIDTH-1:0] mem [2][DEPTH];

    logic      wbank;
    wr_state_t wr_state;
    logic [AW-1:0] wr_addr;
    rd_state_t rd_state;
    logic [RW-1:0] rd_addr;

    logic          wr_en;
    logic [AW-1:0] waddr;
    logic          wr_last;
    logic          rd_accept_start;
    logic          rd_issue;
    logic          rd_finish;
    logic          reader_free;
    logic          drop;

    // Handshake: a beat transfers on a rising edge where rd_valid_o && rd_ready_i;
    // while rd_valid_o is high and rd_ready_i low, rd_data_o/rd_last_o are held.
    always_comb begin
        wr_en           = wr_valid_i && (wr_sof_i || (wr_state == WRITE));
        waddr           = wr_sof_i ? '0 : wr_addr;
        wr_last         = wr_en && (waddr == AW'(DEPTH - 1));
        rd_accept_start = (rd_state == IDLE) && rd_start_i && frame_avail_o;
        rd_issue        = (rd_state == STREAM) && (rd_addr < RW'(DEPTH))
                          && (!rd_valid_o || rd_ready_i);
        rd_finish       = (rd_state == STREAM) && rd_valid_o && rd_ready_i && rd_last_o;
        // A start accepted on the completing cycle claims the old frame, so the
        // new one cannot swap in underneath it and is dropped instead.
        reader_free     = ((rd_state == IDLE) && !rd_accept_start) || rd_finish;
        drop            = wr_last && (!reader_free || frame_avail_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            mem[wbank][waddr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wbank           <= 1'b0;
            wr_state        <= WAIT_SOF;
            wr_addr         <= '0;
            rd_state        <= IDLE;
            rd_addr         <= '0;
            wr_frame_done_o <= 1'b0;
            rd_valid_o      <= 1'b0;
            rd_data_o       <= '0;
            rd_last_o       <= 1'b0;
            frame_avail_o   <= 1'b0;
            drop_count_o    <= '0;
        end else begin
            wr_frame_done_o <= wr_last;
            if (wr_en) begin
                if (wr_last) begin
                    wr_state <= WAIT_SOF;
                    wr_addr  <= '0;
                end else begin
                    wr_state <= WRITE;
                    wr_addr  <= waddr + 1'b1;
                end
            end

            if (rd_accept_start) begin
                frame_avail_o <= 1'b0;
            end
            if (wr_last && reader_free) begin
                wbank         <= ~wbank;
                frame_avail_o <= 1'b1;
            end
            if (drop && (drop_count_o != 16'hFFFF)) begin
                drop_count_o <= drop_count_o + 16'd1;
            end

            case (rd_state)
                IDLE: begin
                    if (rd_accept_start) begin
                        rd_state <= STREAM;
                        rd_addr  <= '0;
                    end
                end
                STREAM: begin
                    if (rd_issue) begin
                        rd_data_o  <= mem[~wbank][rd_addr[AW-1:0]];
                        rd_valid_o <= 1'b1;
                        rd_last_o  <= (rd_addr == RW'(DEPTH - 1));
                        rd_addr    <= rd_addr + 1'b1;
                    end else if (rd_valid_o && rd_ready_i) begin
                        rd_valid_o <= 1'b0;
                        rd_last_o  <= 1'b0;
                    end
                    if (rd_finish) begin
                        rd_state <= IDLE;
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

    assign rd_busy_o = (rd_state == STREAM);

endmodule

// File: doc/frame_buffer_pingpong.md
FRAME_BUFFER_PINGPONG -- requirements
Module: frame_buffer_pingpong

Interface
REQ-001 SHALL have parameter WIDTH, default 12, pixel width in bits.
REQ-002 SHALL have parameter DEPTH, default 76800, pixels per frame per bank.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port wr_sof_i  input  1  start of frame, qualified by wr_valid_i.
REQ-006 SHALL have port wr_valid_i  input  1  write pixel valid.
REQ-007 SHALL have port wr_data_i  input  WIDTH  write pixel.
REQ-008 SHALL have port wr_frame_done_o  output  1  one-cycle pulse on frame completion.
REQ-009 SHALL have port rd_start_i  input  1  request to stream the available frame.
REQ-010 SHALL have port rd_ready_i  input  1  downstream accepts beat.
REQ-011 SHALL have port rd_valid_o  output  1  read beat valid.
REQ-012 SHALL have port rd_data_o  output  WIDTH  read pixel.
REQ-013 SHALL have port rd_last_o  output  1  marks beat DEPTH-1.
REQ-014 SHALL have port rd_busy_o  output  1  read FSM in STREAM.
REQ-015 SHALL have port frame_avail_o  output  1  complete unread frame in read bank.
REQ-016 SHALL have port drop_count_o  output  16  saturating count of undelivered frames.

Function
REQ-017 SHALL hold two banks of DEPTH x WIDTH, one write bank (wbank), read bank = ~wbank.
REQ-018 Writer SHALL have states WAIT_SOF, WRITE; reset into WAIT_SOF.
REQ-019 Beat with wr_valid_i && wr_sof_i in either state SHALL write address 0, set wr_addr=1, enter WRITE; partial frame discarded, no drop counted.
REQ-020 Beat with wr_valid_i && !wr_sof_i in WRITE SHALL write wr_addr and increment; in WAIT_SOF it SHALL be ignored.
REQ-021 Write to address DEPTH-1 SHALL complete frame: pulse wr_frame_done_o next cycle, writer returns to WAIT_SOF.
REQ-022 On completion with reader idle (IDLE, or final beat accepted same cycle): toggle wbank, set frame_avail_o; if frame_avail_o was already 1, increment drop_count_o (superseded frame).
REQ-023 On completion with reader in STREAM and not finishing: no swap, frame dropped, drop_count_o increments; next frame overwrites wbank.
REQ-024 drop_count_o SHALL saturate at 16'hFFFF.
REQ-025 Reader SHALL have states IDLE, STREAM.
REQ-026 rd_start_i in IDLE with frame_avail_o=1 SHALL enter STREAM, clear frame_avail_o, rd_addr=0; otherwise ignored (including same cycle as swap, since frame_avail_o not yet set).
REQ-027 In STREAM, read issue SHALL occur when rd_addr<DEPTH && (!rd_valid_o || rd_ready_i); rd_data_o/rd_valid_o update only on advance.
REQ-028 Latency: rd_start_i accepted cycle T -> first rd_valid_o at T+2; throughput one beat/cycle with rd_ready_i=1.
REQ-029 rd_valid_o && !rd_ready_i SHALL hold rd_data_o, rd_last_o stable.
REQ-030 rd_last_o SHALL assert with beat DEPTH-1; acceptance of that beat SHALL return reader to IDLE and deassert rd_valid_o next cycle unless no new beat.
REQ-031 Read and write banks SHALL never coincide while reader in STREAM.

Reset
REQ-032 rst_ni=0 at rising edge SHALL set: wbank=0, writer WAIT_SOF, wr_addr=0, reader IDLE, rd_addr=0; outputs wr_frame_done_o=0, rd_valid_o=0, rd_data_o=0, rd_last_o=0, rd_busy_o=0, frame_avail_o=0, drop_count_o=0.
REQ-033 Reset mid-operation SHALL abort both streams; RAM contents not cleared and never visible without a new completed frame.

Verification (WIDTH=12, DEPTH=8)
REQ-034 Reset, sof+8 beats data 0x100..0x107 -> wr_frame_done_o pulse, frame_avail_o=1; rd_start_i, rd_ready_i=1 -> rd_valid_o at T+2, data 0x100..0x107 consecutive, rd_last_o on 0x107, rd_busy_o low after.
REQ-035 Stream with rd_ready_i toggling 1/0 -> no beat lost/duplicated, data stable during stalls.
REQ-036 Second frame completes during STREAM -> drop_count_o=1, streamed data unchanged; third frame after IDLE -> swap, frame_avail_o=1.
REQ-037 Two frames complete, no read -> drop_count_o=1, read returns second frame's data.
REQ-038 sof at beat 4, then 8 beats 0x200..0x207 -> read returns 0x200..0x207, drop_count_o=0; beats without sof after reset ignored.
REQ-039 rst_ni=0 mid-stream -> next cycle rd_valid_o=0, frame_avail_o=0, drop_count_o=0.
